// File: rtl/scrambler_pkg.sv
// Shared types, default Galois tap masks and the nonlinear mix round for the
// PUF challenge scrambler family.
package scrambler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_STEP = 2'd1,
        ST_MIX  = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    // Maximal-length masks for a right-shifting Galois LFSR.
    localparam logic [5:0]  TAPS_W6  = 6'h30;
    localparam logic [7:0]  TAPS_W8  = 8'hB8;
    localparam logic [15:0] TAPS_W16 = 16'hB400;
    localparam logic [31:0] TAPS_W32 = 32'h8020_0003;

    localparam int MAX_W = 32;

    function automatic logic [MAX_W-1:0] width_mask(input int w);
        logic [MAX_W-1:0] m;
        if (w >= MAX_W) m = '1;
        else            m = (32'h1 << w) - 32'h1;
        return m;
    endfunction

    // Rotate left within the low w bits; n is always smaller than w here.
    function automatic logic [MAX_W-1:0] rotl(input logic [MAX_W-1:0] x,
                                              input int w, input int n);
        logic [MAX_W-1:0] xm;
        xm = x & width_mask(w);
        return ((xm << n) | (xm >> (w - n))) & width_mask(w);
    endfunction

    function automatic logic [MAX_W-1:0] mix_round(input logic [MAX_W-1:0] x,
                                                   input logic [MAX_W-1:0] k,
                                                   input int w);
        return rotl(x, w, 1) ^ (rotl(x, w, 3) & rotl(x, w, 5)) ^ (k & width_mask(w));
    endfunction

endpackage

// File: rtl/lfsr_galois.sv
// Right-shifting Galois LFSR with synchronous load and advance enables;
// load wins over advance.
module lfsr_galois #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] TAPS     = WIDTH'(8'hB8),
    parameter logic [WIDTH-1:0] SEED_RST = WIDTH'(1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             advance,
    output logic [WIDTH-1:0] state,
    output logic [WIDTH-1:0] next_state
);

    assign next_state = (state >> 1) ^ (state[0] ? TAPS : '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= SEED_RST;
        end else if (load) begin
            state <= load_val;
        end else if (advance) begin
            state <= next_state;
        end
    end

endmodule

// File: rtl/challenge_scrambler.sv
// Burst challenge scrambler: LFSR-whitened base challenge, ROUNDS nonlinear
// mix rounds, one registered result per valid/ready handshake.
//
//   state   | meaning
//   IDLE    | waiting for start; seed_load honoured here only
//   STEP    | advance LFSR, acc = new lfsr ^ base
//   MIX     | ROUNDS cycles of acc = f(acc, lfsr)
//   HOLD    | publish acc on chall_out, wait for out_ready
module challenge_scrambler
    import scrambler_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] TAPS     = WIDTH'(TAPS_W8),
    parameter int               ROUNDS   = 2,
    parameter logic [WIDTH-1:0] SEED_RST = WIDTH'(1),
    parameter int               CNT_W    = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] chall_in,
    input  logic             start,
    input  logic [CNT_W-1:0] burst_len,
    output logic [WIDTH-1:0] chall_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic             seed_zero
);

    localparam int               RND_W    = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam logic [RND_W-1:0] RND_LAST = RND_W'((ROUNDS > 0) ? ROUNDS - 1 : 0);

    state_t           state, state_next;
    logic [WIDTH-1:0] base, acc;
    logic [CNT_W-1:0] remaining;
    logic [RND_W-1:0] rnd;
    logic [WIDTH-1:0] lfsr_q, lfsr_nxt, load_val;
    logic             lfsr_load, lfsr_adv;
    logic             handshake, last_item;

    assign load_val  = (seed_in == '0) ? WIDTH'(1) : seed_in;
    assign handshake = out_valid & out_ready;
    assign last_item = (remaining == CNT_W'(1));
    assign busy      = (state != ST_IDLE);

    lfsr_galois #(
        .WIDTH    (WIDTH),
        .TAPS     (TAPS),
        .SEED_RST (SEED_RST)
    ) u_lfsr (
        .clock      (clock),
        .reset      (reset),
        .load       (lfsr_load),
        .load_val   (load_val),
        .advance    (lfsr_adv),
        .state      (lfsr_q),
        .next_state (lfsr_nxt)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        lfsr_load  = 1'b0;
        lfsr_adv   = 1'b0;
        case (state)
            ST_IDLE: begin
                lfsr_load = seed_load;
                if (start && (burst_len != '0)) state_next = ST_STEP;
            end
            ST_STEP: begin
                lfsr_adv   = 1'b1;
                state_next = (ROUNDS == 0) ? ST_HOLD : ST_MIX;
            end
            ST_MIX: begin
                if (rnd == RND_LAST) state_next = ST_HOLD;
            end
            ST_HOLD: begin
                if (handshake) state_next = last_item ? ST_IDLE : ST_STEP;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            base      <= '0;
            acc       <= '0;
            remaining <= '0;
            rnd       <= '0;
            chall_out <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            seed_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (seed_load) seed_zero <= (seed_in == '0);
                    if (start) begin
                        if (burst_len != '0) begin
                            base      <= chall_in;
                            remaining <= burst_len;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                ST_STEP: begin
                    acc <= lfsr_nxt ^ base;
                    rnd <= '0;
                end
                ST_MIX: begin
                    acc <= WIDTH'(mix_round(MAX_W'(acc), MAX_W'(lfsr_q), WIDTH));
                    rnd <= rnd + 1'b1;
                end
                ST_HOLD: begin
                    // First HOLD cycle publishes; later cycles wait for the consumer.
                    if (!out_valid) begin
                        chall_out <= acc;
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        remaining <= remaining - 1'b1;
                        if (last_item) done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_challenge_scrambler.sv
// Scoreboard bench: ROUNDS=0 and ROUNDS=1 scramblers driven in lockstep,
// expected outputs from a local LFSR/mix model.
module tb_challenge_scrambler;

    logic       clock     = 1'b0;
    logic       reset     = 1'b1;
    logic [7:0] seed_in   = 8'h00;
    logic       seed_load = 1'b0;
    logic [7:0] chall_in  = 8'h00;
    logic       start     = 1'b0;
    logic [7:0] burst_len = 8'h00;
    logic       out_ready = 1'b1;

    logic [7:0] chall_out0, chall_out1;
    logic       out_valid0, out_valid1, busy0, busy1, done0, done1, seed_zero0, seed_zero1;

    always #5 clock = ~clock;

    challenge_scrambler #(.ROUNDS(0)) dut_r0 (
        .clock(clock), .reset(reset), .seed_in(seed_in), .seed_load(seed_load),
        .chall_in(chall_in), .start(start), .burst_len(burst_len),
        .chall_out(chall_out0), .out_valid(out_valid0), .out_ready(out_ready),
        .busy(busy0), .done(done0), .seed_zero(seed_zero0)
    );

    challenge_scrambler #(.ROUNDS(1)) dut_r1 (
        .clock(clock), .reset(reset), .seed_in(seed_in), .seed_load(seed_load),
        .chall_in(chall_in), .start(start), .burst_len(burst_len),
        .chall_out(chall_out1), .out_valid(out_valid1), .out_ready(out_ready),
        .busy(busy1), .done(done1), .seed_zero(seed_zero1)
    );

    int n_checks  = 0;
    int n_fail    = 0;
    int done_cnt0 = 0;
    int done_cnt1 = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] lfsr_m = 8'h01;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] step8(input logic [7:0] s);
        return (s >> 1) ^ (s[0] ? 8'hB8 : 8'h00);
    endfunction

    function automatic logic [7:0] rl(input logic [7:0] x, input int n);
        logic [7:0] r;
        r = (x << n) | (x >> (8 - n));
        return r;
    endfunction

    function automatic logic [7:0] mix8(input logic [7:0] x, input logic [7:0] k);
        return rl(x, 1) ^ (rl(x, 3) & rl(x, 5)) ^ k;
    endfunction

    always @(negedge clock) begin
        if (!reset) begin
            if (done0) done_cnt0++;
            if (done1) done_cnt1++;
            if (out_valid0 && out_ready) begin
                if (q0.size() == 0) check("r0_extra_output", {31'd0, out_valid0}, 32'd0);
                else                check("r0_chall", {24'd0, chall_out0}, {24'd0, q0.pop_front()});
            end
            if (out_valid1 && out_ready) begin
                if (q1.size() == 0) check("r1_extra_output", {31'd0, out_valid1}, 32'd0);
                else                check("r1_chall", {24'd0, chall_out1}, {24'd0, q1.pop_front()});
            end
        end
    end

    task automatic run_burst(input logic [7:0] base, input int len, input int stall,
                             input bit poke, output int lat0, output int lat1);
        logic [7:0] a;
        int d0, d1;
        bit finished;
        for (int i = 0; i < len; i++) begin
            lfsr_m = step8(lfsr_m);
            a = lfsr_m ^ base;
            q0.push_back(a);
            q1.push_back(mix8(a, lfsr_m));
        end
        d0 = done_cnt0;
        d1 = done_cnt1;
        lat0 = -1;
        lat1 = -1;
        finished = 1'b0;
        chall_in  = base;
        burst_len = 8'(len);
        start     = 1'b1;
        if (stall > 0) out_ready = 1'b0;
        @(posedge clock); #1;
        start     = 1'b0;
        seed_load = 1'b0;
        for (int n = 0; n < 4000 && !finished; n++) begin
            @(negedge clock);
            if (out_valid0 && lat0 < 0) lat0 = n;
            if (out_valid1 && lat1 < 0) lat1 = n;
            if (stall > 0 && n >= 6 && n < 6 + stall) begin
                check("bp_r0_valid", {31'd0, out_valid0}, 32'd1);
                check("bp_r1_valid", {31'd0, out_valid1}, 32'd1);
                check("bp_r0_hold", {24'd0, chall_out0}, {24'd0, q0[0]});
                check("bp_r1_hold", {24'd0, chall_out1}, {24'd0, q1[0]});
                if (n == 5 + stall) begin
                    @(posedge clock); #1;
                    out_ready = 1'b1;
                end
            end
            if (poke && n == 10) begin
                start = 1'b1; seed_load = 1'b1; seed_in = 8'h55; burst_len = 8'd5;
            end
            if (poke && n == 11) begin
                start = 1'b0; seed_load = 1'b0;
            end
            if (!busy0 && !busy1 && !start) finished = 1'b1;
        end
        @(negedge clock);
        check("burst_finished", {31'd0, finished}, 32'd1);
        check("r0_done_pulses", done_cnt0 - d0, 32'd1);
        check("r1_done_pulses", done_cnt1 - d1, 32'd1);
        check("r0_queue_drained", q0.size(), 32'd0);
        check("r1_queue_drained", q1.size(), 32'd0);
    endtask

    initial begin
        int l0, l1;
        repeat (2) @(posedge clock);
        #1;
        check("rst_r0_chall", {24'd0, chall_out0}, 32'd0);
        check("rst_r1_chall", {24'd0, chall_out1}, 32'd0);
        check("rst_r0_valid", {31'd0, out_valid0}, 32'd0);
        check("rst_r1_valid", {31'd0, out_valid1}, 32'd0);
        check("rst_r0_busy", {31'd0, busy0}, 32'd0);
        check("rst_r1_busy", {31'd0, busy1}, 32'd0);
        check("rst_r0_done", {31'd0, done0}, 32'd0);
        check("rst_r1_done", {31'd0, done1}, 32'd0);
        check("rst_r0_seed_zero", {31'd0, seed_zero0}, 32'd0);
        check("rst_r1_seed_zero", {31'd0, seed_zero1}, 32'd0);
        reset = 1'b0;

        // Reset seed, base 0x00: 0xB8 then 0x5C on the ROUNDS=0 build.
        run_burst(8'h00, 2, 0, 1'b0, l0, l1);
        check("lat_r0", l0, 32'd2);
        check("lat_r1", l1, 32'd3);

        // Zero seed is replaced by 1 and flagged.
        @(posedge clock); #1;
        seed_in = 8'h00; seed_load = 1'b1;
        @(posedge clock); #1;
        seed_load = 1'b0;
        lfsr_m = 8'h01;
        @(negedge clock);
        check("seed_zero_set_r0", {31'd0, seed_zero0}, 32'd1);
        check("seed_zero_set_r1", {31'd0, seed_zero1}, 32'd1);
        run_burst(8'hFF, 2, 0, 1'b0, l0, l1);

        // Nonzero seed clears the flag; one ROUNDS=1 result from seed 1.
        @(posedge clock); #1;
        seed_in = 8'h01; seed_load = 1'b1;
        @(posedge clock); #1;
        seed_load = 1'b0;
        lfsr_m = 8'h01;
        @(negedge clock);
        check("seed_zero_clr_r0", {31'd0, seed_zero0}, 32'd0);
        check("seed_zero_clr_r1", {31'd0, seed_zero1}, 32'd0);
        run_burst(8'h00, 1, 0, 1'b0, l0, l1);
        check("lat_r1_single", l1, 32'd3);

        // Seed load and start in the same cycle: the burst uses the new seed.
        @(posedge clock); #1;
        seed_in = 8'h2D; seed_load = 1'b1;
        lfsr_m = 8'h2D;
        run_burst(8'h11, 3, 0, 1'b0, l0, l1);

        // Backpressure for 10 cycles mid-burst.
        run_burst(8'h3C, 4, 10, 1'b0, l0, l1);

        // Full period from the reset seed, with ignored requests while busy.
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        lfsr_m = 8'h01;
        run_burst(8'h00, 255, 0, 1'b1, l0, l1);
        run_burst(8'h00, 1, 0, 1'b0, l0, l1);

        // Reset while the ROUNDS=1 build is in MIX.
        @(posedge clock); #1;
        chall_in = 8'h00; burst_len = 8'd3; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        @(posedge clock); #2;
        reset = 1'b1;
        #1;
        check("mid_rst_r0_valid", {31'd0, out_valid0}, 32'd0);
        check("mid_rst_r1_valid", {31'd0, out_valid1}, 32'd0);
        check("mid_rst_r0_busy", {31'd0, busy0}, 32'd0);
        check("mid_rst_r1_busy", {31'd0, busy1}, 32'd0);
        check("mid_rst_r0_done", {31'd0, done0}, 32'd0);
        check("mid_rst_r1_done", {31'd0, done1}, 32'd0);
        q0.delete();
        q1.delete();
        lfsr_m = 8'h01;
        @(posedge clock); #1;
        reset = 1'b0;
        run_burst(8'h00, 1, 0, 1'b0, l0, l1);

        // Zero-length burst: done only, no output.
        run_burst(8'h00, 0, 0, 1'b0, l0, l1);
        check("zero_len_r0_no_valid", l0, 32'hFFFF_FFFF);
        check("zero_len_r1_no_valid", l1, 32'hFFFF_FFFF);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

// File: doc/challenge_scrambler.md
# challenge_scrambler

Parametrised, burst-capable challenge scrambler for the PUF challenge path. A Galois LFSR of configurable width and taps is combined with the incoming base challenge. The result passes through a configurable number of nonlinear mixing rounds. One start request emits a burst of scrambled challenges over a valid/ready handshake. The block sits between the challenge source (UART/serial command decoder) and the PUF arbiter array, and supersedes the fixed 8-bit single-step scrambler.

## Interface
- WIDTH, 8, challenge and LFSR width; must be at least 6.
- TAPS, 8'hB8, Galois feedback mask; the default is maximal length, period 255.
- ROUNDS, 2, nonlinear mix rounds per challenge; 0 is legal.
- SEED_RST, 1, LFSR value at reset; must be nonzero.
- CNT_W, 8, burst counter width.
- clock  in  1  system clock, all logic on the rising edge.
- reset  in  1  asynchronous, active-high.
- seed_in  in  WIDTH  LFSR seed.
- seed_load  in  1  loads seed_in; honoured in IDLE only.
- chall_in  in  WIDTH  base challenge; sampled when start is accepted.
- start  in  1  burst request; honoured in IDLE only.
- burst_len  in  CNT_W  number of challenges; sampled with start.
- chall_out  out  WIDTH  scrambled challenge, registered.
- out_valid  out  1  chall_out is valid.
- out_ready  in  1  consumer accepts chall_out.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at the end of a burst.
- seed_zero  out  1  sticky flag: a zero seed was substituted; cleared by the next nonzero seed_load.

## Operation
- LFSR step: next = (s >> 1) ^ (s[0] ? TAPS : 0).
- Mix round: f(x,k) = rotl(x,1) ^ (rotl(x,3) & rotl(x,5)) ^ k.
  - x is the accumulator; k is the current LFSR state, which is constant during MIX.
- Seed handling: seed_load in IDLE sets lfsr = seed_in, or 1 when seed_in == 0. A zero seed also sets seed_zero.
- FSM states: IDLE, STEP, MIX, HOLD.
  - IDLE → STEP: on start with burst_len != 0. Latch base = chall_in and remaining = burst_len.
  - IDLE, start with burst_len == 0: pulse done on the next cycle and stay in IDLE.
  - STEP (1 cycle): lfsr <= step(lfsr); acc <= step(lfsr) ^ base. Go to MIX, or to HOLD if ROUNDS == 0.
  - MIX (ROUNDS cycles): acc <= f(acc, lfsr), tracked by a round counter. After the last round go to HOLD.
  - HOLD: on entry, chall_out <= acc and out_valid = 1. When out_ready is high, the handshake completes and remaining decrements.
    - If remaining was 1: pulse done and go to IDLE.
    - Otherwise: go to STEP.
- Ignored requests:
  - start and seed_load while busy are ignored; nothing is queued.
  - start and seed_load in the same IDLE cycle: the seed is loaded first, and the burst's first STEP uses the new seed.
- LFSR state persists across bursts, so successive bursts continue the sequence.
- Reset values: state IDLE, lfsr = SEED_RST, and all outputs 0, including chall_out.

## Timing
- Start accepted at edge t:
  - STEP occupies cycle t+1.
  - MIX occupies cycles t+2 .. t+1+ROUNDS.
  - out_valid is high from edge t+2+ROUNDS.
- Back-to-back challenges: handshake at edge h → next out_valid at h+2+ROUNDS. out_valid is low in between.
- Backpressure: while out_valid is high and out_ready is low, chall_out and out_valid hold stable indefinitely.
- chall_out keeps its last value after a handshake and after the burst ends.
- done is asserted in the cycle after the final handshake edge, together with busy = 0.
- A new start is accepted in that same cycle.
- Reset mid-burst clears the burst immediately and asynchronously:
  - out_valid, busy and done drop to 0.
  - lfsr returns to SEED_RST.
  - The partial burst is lost.

## Structure
- Shared package scrambler_pkg holds:
  - the state enum (IDLE/STEP/MIX/HOLD);
  - default TAPS constants per supported WIDTH (6, 8, 16, 32);
  - the rotl and mix-round functions.
- Sub-module lfsr_galois (params WIDTH, TAPS, SEED_RST):
  - inputs: load, load_val, advance;
  - outputs: state, next_state.
- The FSM, round counter, burst counter, accumulator and output register live in challenge_scrambler.

## Test plan
- ROUNDS=0, after reset (seed 0x01), chall_in 0x00, burst_len 2, out_ready high → outputs 0xB8, then 0x5C; done pulses once.
- ROUNDS=0, seed_load 0x00 → seed_zero=1, LFSR=0x01; chall_in 0xFF, burst 2 → outputs 0x47, 0xA3.
- ROUNDS=1, seed 0x01, chall_in 0x00, burst 1 → chall_out 0xCC.
  - out_valid rises 3 edges after the start edge.
- Backpressure: hold out_ready low for 10 cycles mid-burst → chall_out and out_valid are unchanged; the burst then completes with the correct sequence.
- ROUNDS=0, chall_in 0x00, burst 255, then a second burst of 1 → the second burst's output equals the first output (0xB8), confirming period 255.
  - start and seed_load asserted while busy have no effect.
- Reset asserted mid-MIX → out_valid/busy go to 0 immediately; the next burst of 1 with chall_in 0 yields 0xB8 (ROUNDS=0 build).
  - burst_len 0 → done pulses with no out_valid.
